wallace_mul_scheduler: RTL and testbench

Shares one combinational 8x8 Wallace-tree multiplier (`wallaceTreeMultiplier8Bit`) among `NREQ` independent requesters. Requests are arbitrated round-robin, registered into an operand stage, multiplied, and captured in a result stage. Each result returns on a single response channel tagged with the requester index. The block sits between the multiply-issuing clients and the multiplier, and is the only instance that drives its operands.

---
 rtl/wallace_mul_sched_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 37 +++
 rtl/wallaceTreeMultiplier8Bit.sv | 40 ++++
 rtl/wallace_mul_scheduler.sv | 101 ++++++++++
 tb/tb_wallace_mul_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wallace_mul_sched_pkg.sv
// Shared constants, operand payload and round-robin pick helper for the
// shared Wallace multiplier scheduler.
package wallace_mul_sched_pkg;

    localparam int unsigned MUL_W   = 8;
    localparam int unsigned PROD_W  = 16;
    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned PTR_W   = 4;

    typedef struct packed {
        logic [MUL_W-1:0] a;
        logic [MUL_W-1:0] b;
    } mul_ops_t;

    // One-hot grant of the first valid bit at or after ptr, wrapping at nreq.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [PTR_W-1:0]   ptr,
        input int unsigned        nreq
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        logic [PTR_W-1:0]   idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % nreq);
            if (!found && (k < nreq) && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: pointer register plus combinational one-hot grant.
module rr_arbiter
    import wallace_mul_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic            advance,
    output logic [NREQ-1:0] grant_c,
    output logic [IDW-1:0]  grant_id_c
);

    logic [IDW-1:0] rr_ptr;

    // A single requester is always the granted one; handshake still needs valid.
    assign grant_c = (NREQ == 1) ? '1
                   : NREQ'(rr_pick(MAX_REQ'(req_valid), PTR_W'(rr_ptr), NREQ));

    always_comb begin
        grant_id_c = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_c[i]) grant_id_c = IDW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (grant_id_c == IDW'(NREQ - 1)) ? '0 : grant_id_c + IDW'(1);
        end
    end

endmodule

// File: rtl/wallaceTreeMultiplier8Bit.sv
// Unsigned 8x8 multiplier: partial products reduced by a Wallace tree of
// carry-save layers (8 -> 6 -> 4 -> 3 -> 2 rows), then one final adder.
module wallaceTreeMultiplier8Bit
    import wallace_mul_sched_pkg::*;
(
    input  logic [MUL_W-1:0]  a,
    input  logic [MUL_W-1:0]  b,
    output logic [PROD_W-1:0] product
);

    logic [PROD_W-1:0] pp [MUL_W];
    logic [2*PROD_W-1:0] l0, l1, l2, l3, l4, l5;

    // Carry-save adder on whole rows: {carry << 1, sum}; bits above 16 drop out.
    function automatic logic [2*PROD_W-1:0] csa(
        input logic [PROD_W-1:0] x,
        input logic [PROD_W-1:0] y,
        input logic [PROD_W-1:0] z
    );
        logic [PROD_W-1:0] maj;
        maj = (x & y) | (x & z) | (y & z);
        return {maj[PROD_W-2:0], 1'b0, x ^ y ^ z};
    endfunction

    always_comb begin
        for (int i = 0; i < int'(MUL_W); i++) begin
            pp[i] = b[i] ? (PROD_W'(a) << i) : '0;
        end
    end

    assign l0 = csa(pp[0], pp[1], pp[2]);
    assign l1 = csa(pp[3], pp[4], pp[5]);
    assign l2 = csa(l0[PROD_W-1:0], l0[2*PROD_W-1:PROD_W], l1[PROD_W-1:0]);
    assign l3 = csa(l1[2*PROD_W-1:PROD_W], pp[6], pp[7]);
    assign l4 = csa(l2[PROD_W-1:0], l2[2*PROD_W-1:PROD_W], l3[PROD_W-1:0]);
    assign l5 = csa(l4[PROD_W-1:0], l4[2*PROD_W-1:PROD_W], l3[2*PROD_W-1:PROD_W]);

    assign product = l5[PROD_W-1:0] + l5[2*PROD_W-1:PROD_W];

endmodule

// File: rtl/wallace_mul_scheduler.sv
// Shares one Wallace multiplier among NREQ requesters: round-robin grant,
// operand register (S1), multiplier, result register (S2), tagged response.
module wallace_mul_scheduler
    import wallace_mul_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*MUL_W-1:0] req_a,
    input  logic [NREQ*MUL_W-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [PROD_W-1:0]     rsp_product,
    output logic [15:0]           ops_done
);

    logic              op_valid;
    mul_ops_t          op;
    logic [IDW-1:0]    op_id;
    mul_ops_t          sel_op;
    logic              s1_en;
    logic              s2_en;
    logic              hs;
    logic [NREQ-1:0]   grant_c;
    logic [IDW-1:0]    grant_id_c;
    logic [PROD_W-1:0] mul_product;

    assign s2_en     = !rsp_valid || rsp_ready;
    assign s1_en     = !op_valid || s2_en;
    assign req_ready = grant_c & {NREQ{s1_en && !rst}};
    assign hs        = |(req_valid & req_ready);

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .advance    (hs),
        .grant_c    (grant_c),
        .grant_id_c (grant_id_c)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_op = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_c[i]) begin
                sel_op.a = req_a[i*MUL_W +: MUL_W];
                sel_op.b = req_b[i*MUL_W +: MUL_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_valid <= 1'b0;
            op       <= '0;
            op_id    <= '0;
        end else if (s1_en) begin
            op_valid <= hs;
            if (hs) begin
                op    <= sel_op;
                op_id <= grant_id_c;
            end
        end
    end

    wallaceTreeMultiplier8Bit u_mul (
        .a       (op.a),
        .b       (op.b),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            rsp_product <= '0;
            rsp_id      <= '0;
        end else if (s2_en) begin
            rsp_valid   <= op_valid;
            rsp_product <= mul_product;
            rsp_id      <= op_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ops_done <= '0;
        end else if (rsp_valid && rsp_ready) begin
            ops_done <= ops_done + 16'd1;
        end
    end

endmodule

// File: tb/tb_wallace_mul_scheduler.sv
// Bench for wallace_mul_scheduler: directed vector table, multi-cycle corner
// sequences and a random sweep, all checked against a queue-based model.
module tb_wallace_mul_scheduler;

    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int NRAND = 3000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a = '0;
    logic [NREQ*8-1:0] req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_product;
    logic [15:0]       ops_done;

    always #5 clk = ~clk;

    wallace_mul_scheduler #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .ops_done    (ops_done)
    );

    typedef struct {
        int id;
        int prod;
        int cyc;
    } item_t;

    typedef struct {
        int id;
        int a;
        int b;
        int prod;
    } vec_t;

    item_t           mq[$];   // accepted, not yet responded, in grant order
    item_t           rq[$];   // observed responses
    int              gq[$];   // observed grant order
    int              nvec = 0;
    int              nmis = 0;
    int              cyc = 0;
    int              m_ptr = 0;
    int              m_ops = 0;
    logic [NREQ-1:0] hs_last = '0;

    function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return NREQ'(1) << ((p + k) % NREQ);
        end
        return '0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference model: sampled mid-cycle, applies what the next edge does.
    always @(negedge clk) begin
        logic [NREQ-1:0] er;
        logic [NREQ-1:0] hs;
        logic            erv;
        item_t           it;
        cyc++;
        er  = (rst || (mq.size() == 2 && !rsp_ready)) ? '0 : pick(req_valid, m_ptr);
        erv = (mq.size() > 0) && (cyc - mq[0].cyc >= 2);
        chk("req_ready", int'(req_ready), int'(er));
        chk("rsp_valid", int'(rsp_valid), int'(erv));
        chk("ops_done", int'(ops_done), m_ops);
        if (rsp_valid && erv) begin
            chk("rsp_id", int'(rsp_id), mq[0].id);
            chk("rsp_product", int'(rsp_product), mq[0].prod);
        end
        if (rsp_valid && rsp_ready) begin
            if (mq.size() > 0) void'(mq.pop_front());
            it = '{int'(rsp_id), int'(rsp_product), cyc};
            rq.push_back(it);
            m_ops = (m_ops + 1) & 16'hFFFF;
        end
        hs = req_valid & req_ready;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) begin
                it = '{i, int'(req_a[i*8 +: 8]) * int'(req_b[i*8 +: 8]), cyc};
                mq.push_back(it);
                gq.push_back(i);
                m_ptr = (i + 1) % NREQ;
            end
        end
        hs_last = hs;
        if (rst) begin
            mq.delete();
            m_ptr = 0;
            m_ops = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns in the slot just after its handshake edge.
    task automatic issue(input int id, input int a, input int b);
        req_a[id*8 +: 8] = 8'(a);
        req_b[id*8 +: 8] = 8'(b);
        req_valid[id]    = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (hs_last[id]) return;
        end
        chk("issue_timeout", 0, 1);
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (mq.size() == 0) return;
            tick();
        end
        chk("drain_timeout", mq.size(), 0);
    endtask

    vec_t tbl[8];
    int   hcyc;
    int   issued;

    initial begin
        tbl[0] = '{0, 8'hFF, 8'hFF, 16'hFE01};
        tbl[1] = '{1, 8'h00, 8'h00, 16'h0000};
        tbl[2] = '{2, 8'h01, 8'hFF, 16'h00FF};
        tbl[3] = '{3, 8'h80, 8'h02, 16'h0100};
        tbl[4] = '{0, 8'h0F, 8'h0F, 16'h00E1};
        tbl[5] = '{1, 8'hFF, 8'h01, 16'h00FF};
        tbl[6] = '{2, 8'h10, 8'h10, 16'h0100};
        tbl[7] = '{3, 8'hAB, 8'hCD, 16'h88EF};

        repeat (3) tick();
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_product", int'(rsp_product), 0);
        chk("reset_ops_done", int'(ops_done), 0);
        chk("reset_req_ready", int'(req_ready), 0);
        rst = 1'b0;
        tick();

        // Directed table: single request, latency 2, counter steps.
        for (int k = 0; k < 8; k++) begin
            rq.delete();
            issue(tbl[k].id, tbl[k].a, tbl[k].b);
            req_valid[tbl[k].id] = 1'b0;
            hcyc = cyc;
            drain();
            tick();
            chk("tbl_count", rq.size(), 1);
            if (rq.size() > 0) begin
                chk("tbl_product", rq[0].prod, tbl[k].prod);
                chk("tbl_id", rq[0].id, tbl[k].id);
                chk("tbl_latency", rq[0].cyc - hcyc, 2);
            end
            chk("tbl_ops_done", int'(ops_done), k + 1);
        end

        // All requesters valid: grants rotate, one response per cycle.
        gq.delete();
        rq.delete();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*8 +: 8] = 8'(i + 1);
            req_b[i*8 +: 8] = 8'd3;
        end
        req_valid = '1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (gq.size() >= 5) break;
        end
        req_valid = '0;
        drain();
        chk("rot_grants", gq.size(), 5);
        chk("rot_rsps", rq.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < gq.size()) chk("rot_grant", gq[k], k % 4);
            if (k < rq.size()) chk("rot_product", rq[k].prod, 3 * ((k % 4) + 1));
            if (k > 0 && k < rq.size()) chk("rot_spacing", rq[k].cyc - rq[k-1].cyc, 1);
        end

        // Backpressure while requester 2 streams.
        gq.delete();
        rq.delete();
        fork
            begin
                for (int k = 0; k < 5; k++) issue(2, 16 + k, 2);
                req_valid[2] = 1'b0;
            end
            begin
                rsp_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                chk("bp_handshakes", gq.size(), 2);
                chk("bp_req_ready", int'(req_ready), 0);
                rsp_ready = 1'b1;
            end
        join
        drain();
        chk("bp_rsps", rq.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < rq.size()) begin
                chk("bp_product", rq[k].prod, 16'h20 + 2 * k);
                chk("bp_id", rq[k].id, 2);
            end
        end

        // Pointer at 2, requesters 1 and 3 together: 3 wins first.
        issue(1, 5, 5);
        req_valid[1] = 1'b0;
        drain();
        gq.delete();
        req_a[1*8 +: 8] = 8'd1;
        req_b[1*8 +: 8] = 8'd1;
        req_a[3*8 +: 8] = 8'd3;
        req_b[3*8 +: 8] = 8'd3;
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (hs_last[1]) req_valid[1] = 1'b0;
            if (hs_last[3]) req_valid[3] = 1'b0;
            if (gq.size() >= 2) break;
        end
        req_valid = '0;
        chk("pair_grants", gq.size(), 2);
        if (gq.size() >= 2) begin
            chk("pair_first", gq[0], 3);
            chk("pair_second", gq[1], 1);
        end
        drain();

        // Reset with both stages full; pending request survives.
        rsp_ready = 1'b0;
        issue(0, 5, 5);
        issue(0, 6, 6);
        req_a[7:0] = 8'd7;
        req_b[7:0] = 8'd9;
        tick();
        tick();
        chk("full_req_ready", int'(req_ready), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_rsp_valid", int'(rsp_valid), 0);
        chk("post_rst_ops_done", int'(ops_done), 0);
        @(posedge clk);
        #1;
        rq.delete();
        rsp_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (hs_last[0]) break;
            tick();
        end
        req_valid[0] = 1'b0;
        drain();
        tick();
        chk("rst_rsps", rq.size(), 1);
        if (rq.size() > 0) begin
            chk("rst_product", rq[0].prod, 63);
            chk("rst_id", rq[0].id, 0);
        end

        // Random sweep with random backpressure.
        issued = 0;
        for (int c = 0; c < 30000; c++) begin
            if (issued >= NRAND && req_valid == '0) break;
            rsp_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && hs_last[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && issued < NRAND && $urandom_range(1) == 1) begin
                    req_a[i*8 +: 8] = (issued == 1 || issued == 3) ? 8'hFF
                                    : (issued < 4) ? 8'h00 : 8'($urandom_range(255));
                    req_b[i*8 +: 8] = (issued == 1 || issued == 2) ? 8'hFF
                                    : (issued < 4) ? 8'h00 : 8'($urandom_range(255));
                    req_valid[i] = 1'b1;
                    issued++;
                end
            end
            tick();
        end
        chk("rand_issued", issued, NRAND);
        chk("rand_idle", int'(req_valid), 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
